// File: rtl/audio_route_ctrl.sv
// audio_route_ctrl: debounced, click-free sequencing of audio source and bandpass bypass changes.
// Optional macro AUDIO_ROUTE_SOFT_START_EN: reset into FADE_IN with gain 0 so output ramps up from silence.
module audio_route_ctrl #(
    parameter int SAMPLE_W        = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GAIN_STEP       = 4,
    parameter int SETTLE_SAMPLES  = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                sw_source,
    input  logic                sw_filter,
    input  logic                sample_tick,
    input  logic [SAMPLE_W-1:0] synth_sample,
    input  logic [SAMPLE_W-1:0] line_sample,
    input  logic [SAMPLE_W-1:0] filtered_sample,
    output logic [SAMPLE_W-1:0] filter_in_sample,
    output logic [SAMPLE_W-1:0] audio_out_sample,
    output logic                out_valid,
    output logic [8:0]          gain,
    output logic                busy,
    output logic [2:0]          route_state
);
    typedef enum logic [2:0] {IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN} state_t;

    localparam int DB_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [8:0] FULL = 9'd256;
    localparam logic [8:0] STEP = 9'(GAIN_STEP);
`ifdef AUDIO_ROUTE_SOFT_START_EN
    localparam state_t     RST_STATE = FADE_IN;
    localparam logic [8:0] RST_GAIN  = 9'd0;
`else
    localparam state_t     RST_STATE = IDLE;
    localparam logic [8:0] RST_GAIN  = FULL;
`endif

    logic [1:0] w_sw, w_db, r_act, w_act_nxt;
    logic       w_req;
    state_t     r_state, w_state_nxt;
    logic [8:0] r_gain, w_gain_nxt, w_gain_dn, w_gain_up;
    logic [ST_W-1:0] r_settle, w_settle_nxt, w_settle_inc;
    logic signed [SAMPLE_W-1:0] w_raw, w_sel, w_scaled;
    logic signed [SAMPLE_W+9:0] w_prod;

    assign w_sw = {sw_source, sw_filter};

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [2:0]      r_sync;
        logic [DB_W-1:0] r_cnt;
        logic            r_db;
        // bit 1 is the synchronised level, bit 2 its previous value; any movement restarts the count
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_db   <= 1'b0;
            end else begin
                r_sync <= {r_sync[1:0], w_sw[g]};
                if (r_sync[1] != r_sync[2])
                    r_cnt <= '0;
                else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1))
                    r_db <= r_sync[1];
                else
                    r_cnt <= r_cnt + 1'b1;
            end
        end
        assign w_db[g] = r_db;
    end

    assign w_req        = w_db != r_act;
    assign w_gain_dn    = r_gain > STEP ? r_gain - STEP : 9'd0;
    assign w_gain_up    = r_gain < FULL - STEP ? r_gain + STEP : FULL;
    assign w_settle_inc = r_settle + ST_W'(sample_tick);

    assign w_raw    = r_act[1] ? synth_sample : line_sample;
    assign w_sel    = r_act[0] ? filtered_sample : w_raw;
    assign w_prod   = w_sel * $signed({1'b0, r_gain});
    assign w_scaled = SAMPLE_W'(w_prod >>> 8);

    // route sequencer: mute, swap, let the filter flush, then unmute
    always_comb begin
        w_state_nxt  = r_state;
        w_gain_nxt   = r_gain;
        w_settle_nxt = r_settle;
        w_act_nxt    = r_act;
        case (r_state)
            IDLE: begin
                w_gain_nxt = FULL;
                if (w_req) w_state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                if (r_gain == 9'd0) w_state_nxt = SWITCH;
                else if (sample_tick) w_gain_nxt = w_gain_dn;
            end
            SWITCH: begin
                w_act_nxt    = w_db;
                w_gain_nxt   = 9'd0;
                w_settle_nxt = ST_W'(sample_tick);
                w_state_nxt  = SETTLE;
            end
            SETTLE: begin
                w_gain_nxt   = 9'd0;
                w_settle_nxt = w_settle_inc;
                if (w_req) w_state_nxt = SWITCH;
                else if (w_settle_inc >= ST_W'(SETTLE_SAMPLES)) w_state_nxt = FADE_IN;
            end
            FADE_IN: begin
                if (w_req) w_state_nxt = FADE_OUT;
                else if (r_gain == FULL) w_state_nxt = IDLE;
                else if (sample_tick) w_gain_nxt = w_gain_up;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // sequencer state, gain, settle count and active route
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= RST_STATE;
            r_gain   <= RST_GAIN;
            r_settle <= '0;
            r_act    <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_gain   <= w_gain_nxt;
            r_settle <= w_settle_nxt;
            r_act    <= w_act_nxt;
        end
    end

    // sample path: product uses the gain in force before this tick's update
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filter_in_sample <= '0;
            audio_out_sample <= '0;
            out_valid        <= 1'b0;
        end else begin
            out_valid <= sample_tick;
            if (sample_tick) begin
                filter_in_sample <= w_raw;
                audio_out_sample <= w_scaled;
            end
        end
    end

    assign gain        = r_gain;
    assign busy        = r_state != IDLE;
    assign route_state = r_state;
endmodule

// File: tb/tb_audio_route_ctrl.sv
// tb_audio_route_ctrl: directed checks of reset, debounce, route sequencing and mid-sequence reset.
module tb_audio_route_ctrl;
    logic        clk = 1'b0;
    logic        reset, sw_source, sw_filter, sample_tick;
    logic [15:0] synth_sample, line_sample, filtered_sample;
    logic [15:0] filter_in_sample, audio_out_sample;
    logic        out_valid, busy;
    logic [8:0]  gain;
    logic [2:0]  route_state;

    int passed = 0;
    int total  = 0;
    int ph     = 0;
    bit tick_en = 0;
    bit seen_busy;
    int src_exp [13] = '{1000, 750, 500, 250, 0, 0, 0, 0, 0, -500, -1000, -1500, -2000};
    int soft_exp [5] = '{0, 250, 500, 750, 1000};

`ifdef AUDIO_ROUTE_SOFT_START_EN
    localparam int RST_GAIN = 0, RST_STATE = 4, RST_BUSY = 1, RST_OUT = 0;
`else
    localparam int RST_GAIN = 256, RST_STATE = 0, RST_BUSY = 0, RST_OUT = 1000;
`endif

    audio_route_ctrl #(
        .SAMPLE_W(16), .DEBOUNCE_CYCLES(8), .GAIN_STEP(64), .SETTLE_SAMPLES(4)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .sw_source(sw_source), .sw_filter(sw_filter),
        .sample_tick(sample_tick), .synth_sample(synth_sample), .line_sample(line_sample),
        .filtered_sample(filtered_sample), .filter_in_sample(filter_in_sample),
        .audio_out_sample(audio_out_sample), .out_valid(out_valid), .gain(gain),
        .busy(busy), .route_state(route_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        if (tick_en) ph = (ph == 9) ? 0 : ph + 1;
        sample_tick = tick_en && ph == 0;
    endtask

    task automatic wait_state(input string tag, input int st, input int lim);
        for (int i = 0; i < lim && int'(route_state) != st; i++) step();
        chk(tag, int'(route_state), st);
    endtask

    task automatic expect_out(input string tag, input int exp);
        for (int i = 0; i < 30 && !out_valid; i++) step();
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk(tag, int'($signed(audio_out_sample)), exp);
        step();
    endtask

    initial begin
        reset = 1'b1; sw_source = 1'b0; sw_filter = 1'b0; sample_tick = 1'b0;
        synth_sample = 16'(-2000); line_sample = 16'd1000; filtered_sample = 16'd300;
        repeat (3) step();
        chk("rst_gain", int'(gain), RST_GAIN);
        chk("rst_state", int'(route_state), RST_STATE);
        chk("rst_busy", int'(busy), RST_BUSY);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_out", int'(audio_out_sample), 0);
        reset = 1'b0;
        tick_en = 1;
`ifdef AUDIO_ROUTE_SOFT_START_EN
        for (int i = 0; i < 5; i++) expect_out("soft_seq", soft_exp[i]);
`else
        expect_out("first_out", 1000);
`endif
        chk("one_cycle_valid", int'(out_valid), 0);
        chk("idle_state", int'(route_state), 0);
        chk("idle_gain", int'(gain), 256);
        chk("idle_busy", int'(busy), 0);

        sw_source = 1'b1;
        repeat (5) step();
        sw_source = 1'b0;
        seen_busy = 0;
        repeat (40) begin
            step();
            if (busy) seen_busy = 1;
        end
        chk("glitch_busy", int'(seen_busy), 0);
        chk("glitch_gain", int'(gain), 256);

        sw_source = 1'b1;
        wait_state("src_fade_out", 1, 100);
        step();
        for (int i = 0; i < 13; i++) expect_out("src_seq", src_exp[i]);
        chk("src_idle", int'(route_state), 0);
        chk("src_act", int'($signed(filter_in_sample)), -2000);

        sw_source = 1'b0;
        wait_state("back_fade_in", 4, 300);
        for (int i = 0; i < 60 && gain !== 9'd128; i++) step();
        chk("fi_gain128", int'(gain), 128);
        chk("fi_state", int'(route_state), 4);
        tick_en = 0;
        sw_filter = 1'b1;
        wait_state("filt_fade_out", 1, 50);
        chk("filt_start_gain", int'(gain), 128);
        tick_en = 1;
        for (int i = 0; i < 30 && gain === 9'd128; i++) step();
        chk("filt_gain64", int'(gain), 64);
        for (int i = 0; i < 30 && gain === 9'd64; i++) step();
        chk("filt_gain0", int'(gain), 0);
        wait_state("filt_switch", 2, 5);
        wait_state("filt_idle", 0, 300);
        expect_out("filt_out", 300);
        chk("filt_src_line", int'(filter_in_sample), 1000);

        sw_source = 1'b1;
        wait_state("settle_enter", 3, 200);
        repeat (2) step();
        reset = 1'b1; sw_source = 1'b0; sw_filter = 1'b0;
        step();
        chk("mid_rst_state", int'(route_state), RST_STATE);
        chk("mid_rst_gain", int'(gain), RST_GAIN);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(audio_out_sample), 0);
        chk("mid_rst_fin", int'(filter_in_sample), 0);
        reset = 1'b0;
        expect_out("post_rst_out", RST_OUT);
        chk("post_rst_act", int'(filter_in_sample), 1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/audio_route_ctrl.md
Name: audio_route_ctrl

Overview:
- Sequences audio-source and filter-bypass changes for the synth/line-in/bandpass audio path, replacing raw switch muxing.
- Debounces the source and filter switches.
- On each change: ramps gain to zero, swaps the route, waits for the filter to flush, then ramps gain back up.
- Sits between the sample sources, the bandpass filter and the codec interface, so route changes are click-free.

Parameters:
- SAMPLE_W, 16, signed sample width.
- DEBOUNCE_CYCLES, 500000, CLOCK_50 cycles a switch must be stable (10 ms).
- GAIN_STEP, 4, gain change per sample tick during ramps. Must divide 256.
- SETTLE_SAMPLES, 32, sample ticks held muted after a swap so the filter history flushes.

Ports:
- CLOCK_50, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- sw_source, input, 1, asynchronous switch: 1 = synth, 0 = line-in.
- sw_filter, input, 1, asynchronous switch: 1 = route through bandpass.
- sample_tick, input, 1, one-cycle strobe per audio sample (48 kHz).
- synth_sample, input, SAMPLE_W, synth sample, valid on sample_tick.
- line_sample, input, SAMPLE_W, line-in sample, valid on sample_tick.
- filtered_sample, input, SAMPLE_W, bandpass output, valid on sample_tick.
- filter_in_sample, output, SAMPLE_W, selected raw source, fed to the filter.
- audio_out_sample, output, SAMPLE_W, gain-scaled output to the codec.
- out_valid, output, 1, one-cycle strobe marking audio_out_sample.
- gain, output, 9, current gain (0..256).
- busy, output, 1, high in any state other than IDLE.
- route_state, output, 3, FSM state encoding for LEDs/HEX.

Behaviour:
- Synchronisation: each switch passes through a 2-FF synchroniser, then a debounce counter.
  - The counter clears on any change of the synchronised value.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value updates.
- Active config {act_src, act_filt} is registered and changes only in SWITCH.
- request = ({db_src, db_filt} != {act_src, act_filt}).
- filter_in_sample = act_src ? synth_sample : line_sample. Registered on sample_tick.
- Selected sample sel = act_filt ? filtered_sample : filter_in_sample (raw source).
- audio_out_sample = (sel * gain) >>> 8.
  - Signed × unsigned multiply, 26-bit product, arithmetic shift, truncated to SAMPLE_W.
  - gain = 256 passes the sample exactly; gain = 0 gives 0.
- Latency: audio_out_sample and out_valid are registered in the cycle after sample_tick. out_valid is high for exactly that one cycle.
- Gain updates only on sample_tick, after that tick's product is computed (the new gain applies from the next sample).
- FSM states (encoding 0..4): IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN.
  - IDLE: gain = 256. If request, go to FADE_OUT.
  - FADE_OUT: on each tick, gain = max(gain - GAIN_STEP, 0). When gain == 0, go to SWITCH.
  - SWITCH: one cycle. Latch the active config from the debounced values at that cycle. Clear the settle counter. Go to SETTLE.
  - SETTLE: gain held at 0; count ticks.
    - If request is reasserted (switches changed again), go back to SWITCH.
    - Otherwise, after SETTLE_SAMPLES ticks, go to FADE_IN.
  - FADE_IN: on each tick, gain = min(gain + GAIN_STEP, 256).
    - If request asserts, go to FADE_OUT from the current gain (no gain jump).
    - When gain == 256, go to IDLE.
- Simultaneous events:
  - A sample_tick in the SWITCH cycle is still processed: muted output, counted toward settle.
  - Switch changes during FADE_OUT do not restart the ramp; they are picked up in SWITCH.
- Reset (any cycle, including mid-ramp):
  - Synchronisers, debounced values, act_src, act_filt and counters go to 0.
  - filter_in_sample, audio_out_sample and out_valid go to 0.
  - gain and FSM state per the optional feature.

Optional Feature:
- Macro: AUDIO_ROUTE_SOFT_START_EN.
- Defined: reset gives gain = 0 and state FADE_IN, so output ramps from silence after reset. busy = 1 until gain reaches 256.
- Undefined: reset gives gain = 256 and state IDLE. busy = 0.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, GAIN_STEP=64, SETTLE_SAMPLES=4, sample_tick every 10 cycles.
- Reset, macro undefined, line_sample = 1000, switches 0 → first out_valid gives audio_out_sample = 1000; gain = 256; busy = 0; route_state = 0.
- Reset with macro defined, line_sample = 1000 → successive outputs 0, 250, 500, 750, 1000; then IDLE.
- sw_source 0→1, stable, synth_sample = -2000 → after debounce, FADE_OUT outputs 750, 500, 250, 0 (line = 1000). Then SWITCH, 4 ticks of 0, then -500, -1000, -1500, -2000; act_src = 1.
- sw_source glitch high for 5 cycles → no debounced change; gain stays 256; busy = 0.
- sw_filter 0→1 while in FADE_IN at gain 128 → FADE_OUT starts at 128 (next gains 64, 0). act_filt = 1 after SWITCH. Output then follows filtered_sample.
- Assert reset during SETTLE → next cycle: state, gain and act_* at reset values; out_valid = 0; audio_out_sample = 0.
